axi_burst_master: RTL



---
 rtl/axi_burst_master_if.sv | 44 ++++
 rtl/axi_burst_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master_if.sv
// Channel bundle (AW/W/B and AR/R) between the burst master and the memory-side slave.
// Signal names follow the bus documentation, hence the upper case.
interface axi_burst_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WLAST;
  logic              WREADY;
  logic              BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RLAST;
  logic              RRESP;
  logic              RREADY;

  modport master (
    output AWADDR, AWBURST, AWVALID, input AWREADY,
    output WDATA, WVALID, WLAST, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARBURST, ARVALID, input ARREADY,
    input RDATA, RVALID, RLAST, RRESP, output RREADY
  );

  modport slave (
    input AWADDR, AWBURST, AWVALID, output AWREADY,
    input WDATA, WVALID, WLAST, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARBURST, ARVALID, output ARREADY,
    output RDATA, RVALID, RLAST, RRESP, input RREADY
  );
endinterface

// File: rtl/axi_burst_master.sv
// Burst initiator: independent write (AW/W/B) and read (AR/R) engines, each with
// a handshake watchdog that aborts the burst and pulses err when the slave stalls.
module axi_burst_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int ADDR_STEP = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [LEN_W-1:0]  i_wr_len,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_data_valid,
  output logic              o_wr_data_ready,
  output logic              o_wr_busy,
  output logic              o_wr_done,
  output logic              o_wr_err,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [LEN_W-1:0]  i_rd_len,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_valid,
  output logic              o_rd_busy,
  output logic              o_rd_done,
  output logic              o_rd_err,
  axi_burst_master_if.master bus
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

  // ADDR_STEP is informational only: the slave advances the address per beat.
  if (ADDR_STEP <= 0) begin : g_addr_step_unused
  end

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t          r_w_state;
  logic [LEN_W-1:0]  r_w_beats;
  logic [LEN_W-1:0]  r_w_pops;
  logic [TMO_W-1:0]  r_w_tmo;
  logic [ADDR_W-1:0] r_awaddr;
  logic [LEN_W-1:0]  r_awburst;
  logic              r_awvalid;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wvalid;
  logic              r_wlast;
  logic              r_bready;
  logic              r_wr_done;
  logic              r_wr_err;

  r_state_t          r_r_state;
  logic [LEN_W-1:0]  r_r_beats;
  logic [TMO_W-1:0]  r_r_tmo;
  logic              r_r_sticky;
  logic [ADDR_W-1:0] r_araddr;
  logic [LEN_W-1:0]  r_arburst;
  logic              r_arvalid;
  logic              r_rready;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_done;
  logic              r_rd_err;

  logic w_aw_hs, w_w_hs, w_b_hs, w_pop_rdy, w_pop, w_w_expire;
  logic w_ar_hs, w_r_beat, w_r_final, w_r_bad, w_r_expire;

  assign w_aw_hs    = r_awvalid & bus.AWREADY;
  assign w_w_hs     = r_wvalid & bus.WREADY;
  assign w_b_hs     = r_bready & bus.BVALID;
  // The output register refills when empty or draining this cycle, never past len pops.
  assign w_pop_rdy  = (r_w_state == W_DATA) && (r_w_pops != LEN_ZERO) && (!r_wvalid || bus.WREADY);
  assign w_pop      = w_pop_rdy & i_wr_data_valid;
  assign w_w_expire = (r_w_tmo == TMO_LAST);

  assign w_ar_hs    = r_arvalid & bus.ARREADY;
  assign w_r_beat   = r_rready & bus.RVALID;
  assign w_r_final  = (r_r_beats == LEN_ONE) || bus.RLAST;
  assign w_r_bad    = !bus.RRESP || (bus.RLAST != (r_r_beats == LEN_ONE));
  assign w_r_expire = (r_r_tmo == TMO_LAST);

  // Write engine FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_state <= W_IDLE;
      r_w_beats <= LEN_ZERO;
      r_w_pops  <= LEN_ZERO;
      r_w_tmo   <= '0;
      r_awaddr  <= '0;
      r_awburst <= LEN_ZERO;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
      case (r_w_state)
        W_IDLE: begin
          r_w_tmo <= '0;
          if (i_wr_req && (i_wr_len != LEN_ZERO)) begin
            r_awaddr  <= i_wr_addr;
            r_awburst <= i_wr_len;
            r_awvalid <= 1'b1;
            r_w_beats <= i_wr_len;
            r_w_pops  <= i_wr_len;
            r_w_state <= W_ADDR;
          end else if (i_wr_req) begin
            r_wr_err <= 1'b1;
          end else begin
            r_w_state <= W_IDLE;
          end
        end
        W_ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_w_tmo   <= '0;
            r_w_state <= W_DATA;
          end else if (w_w_expire) begin
            r_awvalid <= 1'b0;
            r_w_tmo   <= '0;
            r_wr_err  <= 1'b1;
            r_w_state <= W_IDLE;
          end else begin
            r_w_tmo <= r_w_tmo + TMO_ONE;
          end
        end
        W_DATA: begin
          if (w_pop) begin
            r_wdata  <= i_wr_data;
            r_wvalid <= 1'b1;
            r_wlast  <= (r_w_pops == LEN_ONE);
            r_w_pops <= r_w_pops - LEN_ONE;
          end else if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
          end
          if (w_w_hs) begin
            r_w_beats <= r_w_beats - LEN_ONE;
          end
          if (w_w_hs && (r_w_beats == LEN_ONE)) begin
            r_bready  <= 1'b1;
            r_w_tmo   <= '0;
            r_w_state <= W_RESP;
          end else if (w_w_hs || w_pop) begin
            r_w_tmo <= '0;
          end else if (w_w_expire) begin
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_w_tmo   <= '0;
            r_wr_err  <= 1'b1;
            r_w_state <= W_IDLE;
          end else begin
            r_w_tmo <= r_w_tmo + TMO_ONE;
          end
        end
        W_RESP: begin
          if (w_b_hs || w_w_expire) begin
            r_bready  <= 1'b0;
            r_w_tmo   <= '0;
            r_wr_done <= w_b_hs & bus.BRESP;
            r_wr_err  <= !(w_b_hs & bus.BRESP);
            r_w_state <= W_IDLE;
          end else begin
            r_w_tmo <= r_w_tmo + TMO_ONE;
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_wlast   <= 1'b0;
          r_bready  <= 1'b0;
          r_w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Read engine FSM; protocol errors are collected and reported at the final beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r_state  <= R_IDLE;
      r_r_beats  <= LEN_ZERO;
      r_r_tmo    <= '0;
      r_r_sticky <= 1'b0;
      r_araddr   <= '0;
      r_arburst  <= LEN_ZERO;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_done  <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_done  <= 1'b0;
      r_rd_err   <= 1'b0;
      case (r_r_state)
        R_IDLE: begin
          r_r_tmo <= '0;
          if (i_rd_req && (i_rd_len != LEN_ZERO)) begin
            r_araddr   <= i_rd_addr;
            r_arburst  <= i_rd_len;
            r_arvalid  <= 1'b1;
            r_r_beats  <= i_rd_len;
            r_r_sticky <= 1'b0;
            r_r_state  <= R_ADDR;
          end else if (i_rd_req) begin
            r_rd_err <= 1'b1;
          end else begin
            r_r_state <= R_IDLE;
          end
        end
        R_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_r_tmo   <= '0;
            r_r_state <= R_DATA;
          end else if (w_r_expire) begin
            r_arvalid <= 1'b0;
            r_r_tmo   <= '0;
            r_rd_err  <= 1'b1;
            r_r_state <= R_IDLE;
          end else begin
            r_r_tmo <= r_r_tmo + TMO_ONE;
          end
        end
        R_DATA: begin
          if (w_r_beat) begin
            r_rd_data  <= bus.RDATA;
            r_rd_valid <= 1'b1;
            r_r_beats  <= r_r_beats - LEN_ONE;
            r_r_tmo    <= '0;
            r_r_sticky <= r_r_sticky | w_r_bad;
            if (w_r_final) begin
              r_rready  <= 1'b0;
              r_rd_done <= !(r_r_sticky | w_r_bad);
              r_rd_err  <= r_r_sticky | w_r_bad;
              r_r_state <= R_IDLE;
            end else begin
              r_r_state <= R_DATA;
            end
          end else if (w_r_expire) begin
            r_rready  <= 1'b0;
            r_r_tmo   <= '0;
            r_rd_err  <= 1'b1;
            r_r_state <= R_IDLE;
          end else begin
            r_r_tmo <= r_r_tmo + TMO_ONE;
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_r_state <= R_IDLE;
        end
      endcase
    end
  end

  assign bus.AWADDR      = r_awaddr;
  assign bus.AWBURST     = r_awburst;
  assign bus.AWVALID     = r_awvalid;
  assign bus.WDATA       = r_wdata;
  assign bus.WVALID      = r_wvalid;
  assign bus.WLAST       = r_wlast;
  assign bus.BREADY      = r_bready;
  assign bus.ARADDR      = r_araddr;
  assign bus.ARBURST     = r_arburst;
  assign bus.ARVALID     = r_arvalid;
  assign bus.RREADY      = r_rready;

  assign o_wr_data_ready = w_pop_rdy;
  assign o_wr_busy       = (r_w_state != W_IDLE);
  assign o_wr_done       = r_wr_done;
  assign o_wr_err        = r_wr_err;
  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_valid;
  assign o_rd_busy       = (r_r_state != R_IDLE);
  assign o_rd_done       = r_rd_done;
  assign o_rd_err        = r_rd_err;

endmodule
